// File: rtl/shift_reg_univ_if.sv
// shift_reg_univ_if: control, data and status bundle for the universal shift
// register. The master drives mode/data/burst requests and observes the word
// and handshake; the slave is the register itself.
interface shift_reg_univ_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             enable_i;
    logic [1:0]       mode_i;
    logic [WIDTH-1:0] d_i;
    logic             ser_in_r_i;
    logic             ser_in_l_i;
    logic             rotate_i;
    logic             start_i;
    logic [CW-1:0]    count_i;

    logic [WIDTH-1:0] q_o;
    logic             ser_out_r_o;
    logic             ser_out_l_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output enable_i, mode_i, d_i, ser_in_r_i, ser_in_l_i, rotate_i,
               start_i, count_i,
        input  q_o, ser_out_r_o, ser_out_l_o, busy_o, done_o
    );

    modport slave (
        input  enable_i, mode_i, d_i, ser_in_r_i, ser_in_l_i, rotate_i,
               start_i, count_i,
        output q_o, ser_out_r_o, ser_out_l_o, busy_o, done_o
    );
endinterface

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: WIDTH-bit universal shift register (hold / shift right /
// shift left / parallel load) with an autonomous N-position burst engine and
// a Busy/Done handshake. All state changes on the falling edge of clock_i;
// reset_i is synchronous and active-high.
// Optional feature: define UNIV_SHIFT_ROTATE_EN to let rotate_i turn every
// shift (mode or burst) into a circular shift.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic               clock_i,
    input  logic               reset_i,
    shift_reg_univ_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BURST = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    remaining_q, remaining_d;
    logic             dir_left_q, dir_left_d;

    mode_e            mode;
    logic             mode_is_shift;
    logic             rotate_eff;

    assign mode          = mode_e'(bus.mode_i);
    assign mode_is_shift = (mode == MODE_SHR) || (mode == MODE_SHL);

`ifdef UNIV_SHIFT_ROTATE_EN
    assign rotate_eff = bus.rotate_i;
`else
    // Rotate request is accepted on the port but has no effect in this build.
    logic unused_rotate;
    assign unused_rotate = bus.rotate_i;
    assign rotate_eff    = 1'b0;
`endif

    // One-position shift of a word; the entering bit is the serial input on
    // that side, or the bit leaving the other end when rotating.
    function automatic logic [WIDTH-1:0] shift_word(
        input logic [WIDTH-1:0] word,
        input logic             left,
        input logic             ser_r,
        input logic             ser_l,
        input logic             rot
    );
        logic fill;
        if (left) begin
            fill = rot ? word[WIDTH-1] : ser_l;
            return {word[WIDTH-2:0], fill};
        end
        fill = rot ? word[0] : ser_r;
        return {fill, word[WIDTH-1:1]};
    endfunction

    // Next-state: IDLE register operations, burst launch, burst shifting and
    // the single-cycle completion state.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        q_d         = q_q;
        remaining_d = remaining_q;
        dir_left_d  = dir_left_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i && mode_is_shift) begin
                    // Burst launch: Q untouched on the launch edge.
                    dir_left_d  = (mode == MODE_SHL);
                    remaining_d = bus.count_i;
                    state_d     = (bus.count_i == '0) ? S_DONE : S_BURST;
                end else if (bus.enable_i) begin
                    unique case (mode)
                        MODE_HOLD: q_d = q_q;
                        MODE_SHR:  q_d = shift_word(q_q, 1'b0, bus.ser_in_r_i,
                                                    bus.ser_in_l_i, rotate_eff);
                        MODE_SHL:  q_d = shift_word(q_q, 1'b1, bus.ser_in_r_i,
                                                    bus.ser_in_l_i, rotate_eff);
                        MODE_LOAD: q_d = bus.d_i;
                    endcase
                end
            end

            S_BURST: begin
                // Mode, D, Enable and Start are ignored; serial/rotate inputs live.
                q_d         = shift_word(q_q, dir_left_q, bus.ser_in_r_i,
                                         bus.ser_in_l_i, rotate_eff);
                remaining_d = remaining_q - CW'(1);
                if (remaining_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register, falling-edge with synchronous reset that abandons any burst.
    always_ff @(negedge clock_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of all the others.
        if (reset_i) begin
            state_q     <= S_IDLE;
            q_q         <= '0;
            remaining_q <= '0;
            dir_left_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            remaining_q <= remaining_d;
            dir_left_q  <= dir_left_d;
        end
    end

    // Outputs come straight from registered state.
    assign bus.q_o         = q_q;
    assign bus.ser_out_r_o = q_q[0];
    assign bus.ser_out_l_o = q_q[WIDTH-1];
    assign bus.busy_o      = (state_q == S_BURST);
    assign bus.done_o      = (state_q == S_DONE);

    // Handshake sanity: Busy and Done are exclusive, Done never lasts two cycles.
    a_busy_done_excl: assert property (
        @(negedge clock_i) disable iff (reset_i) !(bus.busy_o && bus.done_o));
    a_done_single: assert property (
        @(negedge clock_i) disable iff (reset_i) bus.done_o |=> !bus.done_o);

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: table-driven vectors, hand-written burst/reset sequences
// and a randomized run against an arithmetic reference model.
// Honors UNIV_SHIFT_ROTATE_EN the same way the design does.
module tb_shift_reg_univ;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

`ifdef UNIV_SHIFT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shift_reg_univ_if #(.WIDTH(W), .CW(CW)) bus ();

    shift_reg_univ #(.WIDTH(W), .CW(CW)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] model_q;

    typedef struct {
        logic         en;
        logic [1:0]   mode;
        logic [W-1:0] d;
        logic         sir;
        logic         sil;
        logic         start;
        logic [W-1:0] exp_q;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference shift using integer arithmetic on the word's value.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] q, input bit left,
                                               input bit in_r, input bit in_l,
                                               input bit rot);
        int v   = int'(q);
        int top = 1 << (W - 1);
        bit fill;
        if (!left) begin
            fill = (rot && ROT_EN) ? (v % 2 == 1) : in_r;
            v    = v / 2 + (fill ? top : 0);
        end else begin
            fill = (rot && ROT_EN) ? (v >= top) : in_l;
            v    = (v * 2) % (1 << W) + (fill ? 1 : 0);
        end
        return v[W-1:0];
    endfunction

    function automatic vec_t mk(input logic en, input logic [1:0] mode,
                                input logic [W-1:0] d, input logic sir,
                                input logic sil, input logic start,
                                input logic [W-1:0] exp_q);
        vec_t v;
        v.en = en; v.mode = mode; v.d = d; v.sir = sir; v.sil = sil;
        v.start = start; v.exp_q = exp_q;
        return v;
    endfunction

    // One active (falling) edge, then return at the rising edge for sampling.
    task automatic step();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic idle_inputs();
        bus.enable_i   = 1'b0;
        bus.mode_i     = 2'b00;
        bus.d_i        = '0;
        bus.ser_in_r_i = 1'b0;
        bus.ser_in_l_i = 1'b0;
        bus.rotate_i   = 1'b0;
        bus.start_i    = 1'b0;
        bus.count_i    = '0;
    endtask

    task automatic check_q(input string tag, input logic [W-1:0] exp);
        check({tag, "_q"}, bus.q_o, exp);
        check({tag, "_sor"}, bus.ser_out_r_o, exp[0]);
        check({tag, "_sol"}, bus.ser_out_l_o, exp[W-1]);
    endtask

    task automatic load(input logic [W-1:0] value);
        idle_inputs();
        bus.enable_i = 1'b1;
        bus.mode_i   = 2'b11;
        bus.d_i      = value;
        step();
        model_q = value;
        check("load_q", bus.q_o, value);
        idle_inputs();
    endtask

    // Launch a burst and follow it to completion, checking length, Done pulse
    // and final word. poke_start keeps requesting new bursts while busy/done.
    task automatic do_burst(input bit left, input logic [CW-1:0] cnt, input bit rot,
                            input bit rand_ser, input bit poke_start);
        int budget;
        int busy_cycles;
        bit sr;
        bit sl;
        idle_inputs();
        bus.start_i  = 1'b1;
        bus.enable_i = 1'b1;
        bus.mode_i   = left ? 2'b10 : 2'b01;
        bus.count_i  = cnt;
        bus.rotate_i = rot;
        bus.d_i      = ~model_q;
        step();
        check("burst_launch_q", bus.q_o, model_q);
        check("burst_launch_busy", bus.busy_o, (cnt != 0));
        check("burst_launch_done", bus.done_o, (cnt == 0));
        busy_cycles = 0;
        budget      = 40;
        while (bus.busy_o === 1'b1 && budget > 0) begin
            sr = rand_ser ? bit'($urandom_range(0, 1)) : 1'b0;
            sl = rand_ser ? bit'($urandom_range(0, 1)) : 1'b0;
            bus.ser_in_r_i = sr;
            bus.ser_in_l_i = sl;
            bus.start_i    = poke_start;
            bus.mode_i     = 2'($urandom_range(0, 3));
            bus.d_i        = W'($urandom);
            bus.count_i    = CW'($urandom_range(1, 3));
            step();
            model_q = ref_shift(model_q, left, sr, sl, rot);
            busy_cycles++;
            budget--;
        end
        check("burst_len", busy_cycles, cnt);
        check("burst_done", bus.done_o, 1'b1);
        check("burst_end_busy", bus.busy_o, 1'b0);
        check_q("burst_end", model_q);
        bus.start_i  = poke_start;
        bus.enable_i = 1'b1;
        bus.mode_i   = 2'b10;
        bus.count_i  = CW'(1);
        step();
        check("after_done_done", bus.done_o, 1'b0);
        check("after_done_busy", bus.busy_o, 1'b0);
        check("after_done_q", bus.q_o, model_q);
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check("reset_q", bus.q_o, 8'h00);
        check("reset_busy", bus.busy_o, 1'b0);
        check("reset_done", bus.done_o, 1'b0);
        rst     = 1'b0;
        model_q = '0;

        // ---- table-driven single-edge operations ----
        vecs.push_back(mk(1, 2'b11, 8'hA5, 0, 0, 0, 8'hA5));
        vecs.push_back(mk(1, 2'b01, 8'h00, 1, 0, 0, 8'hD2));
        vecs.push_back(mk(1, 2'b11, 8'h81, 0, 0, 0, 8'h81));
        vecs.push_back(mk(1, 2'b10, 8'h00, 0, 0, 0, 8'h02));
        vecs.push_back(mk(0, 2'b10, 8'h00, 0, 1, 0, 8'h02));
        vecs.push_back(mk(1, 2'b10, 8'h00, 0, 1, 0, 8'h05));
        vecs.push_back(mk(1, 2'b00, 8'hFF, 1, 1, 0, 8'h05));
        vecs.push_back(mk(1, 2'b01, 8'h00, 0, 1, 0, 8'h02));
        vecs.push_back(mk(1, 2'b11, 8'hFF, 0, 0, 0, 8'hFF));
        vecs.push_back(mk(1, 2'b01, 8'h00, 0, 1, 0, 8'h7F));
        vecs.push_back(mk(1, 2'b10, 8'h00, 0, 1, 0, 8'hFF));
        vecs.push_back(mk(1, 2'b11, 8'h3C, 0, 0, 1, 8'h3C));
        vecs.push_back(mk(1, 2'b00, 8'h00, 0, 0, 1, 8'h3C));
        vecs.push_back(mk(0, 2'b11, 8'h99, 0, 0, 1, 8'h3C));
        foreach (vecs[i]) begin
            bus.enable_i   = vecs[i].en;
            bus.mode_i     = vecs[i].mode;
            bus.d_i        = vecs[i].d;
            bus.ser_in_r_i = vecs[i].sir;
            bus.ser_in_l_i = vecs[i].sil;
            bus.start_i    = vecs[i].start;
            bus.count_i    = CW'(2);
            step();
            check_q($sformatf("vec%0d", i), vecs[i].exp_q);
            check($sformatf("vec%0d_busy", i), bus.busy_o, 1'b0);
            check($sformatf("vec%0d_done", i), bus.done_o, 1'b0);
        end
        idle_inputs();
        model_q = 8'h3C;

        // ---- burst left by 3 with Start poked while busy ----
        load(8'h0F);
        do_burst(1'b1, CW'(3), 1'b0, 1'b0, 1'b1);
        check("burst3_value", bus.q_o, 8'h78);

        // ---- back-to-back burst, right by 2 ----
        do_burst(1'b0, CW'(2), 1'b0, 1'b1, 1'b0);

        // ---- Count = 0 ----
        load(8'h5A);
        do_burst(1'b1, CW'(0), 1'b0, 1'b0, 1'b0);
        check("count0_value", bus.q_o, 8'h5A);

        // ---- Count > WIDTH flushes through ----
        load(8'hC3);
        do_burst(1'b0, CW'(11), 1'b0, 1'b1, 1'b0);

        // ---- rotate, burst and mode shift ----
        load(8'h81);
        do_burst(1'b0, CW'(1), 1'b1, 1'b0, 1'b0);
        check("rot_burst_value", bus.q_o, ROT_EN ? 8'hC0 : 8'h40);
        load(8'h81);
        bus.enable_i = 1'b1;
        bus.mode_i   = 2'b10;
        bus.rotate_i = 1'b1;
        step();
        check("rot_mode_value", bus.q_o, ROT_EN ? 8'h03 : 8'h02);
        idle_inputs();

        // ---- reset on the second burst edge ----
        load(8'h0F);
        bus.start_i = 1'b1;
        bus.mode_i  = 2'b10;
        bus.count_i = CW'(5);
        step();
        bus.start_i = 1'b0;
        step();
        check("rst_mid_busy_before", bus.busy_o, 1'b1);
        check("rst_mid_q_before", bus.q_o, 8'h1E);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        check("rst_mid_q", bus.q_o, 8'h00);
        check("rst_mid_busy", bus.busy_o, 1'b0);
        check("rst_mid_done", bus.done_o, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("rst_mid_no_done", bus.done_o, 1'b0);
            check("rst_mid_no_busy", bus.busy_o, 1'b0);
        end
        model_q = '0;

        // ---- reset beats a simultaneous load ----
        load(8'hEE);
        rst          = 1'b1;
        bus.enable_i = 1'b1;
        bus.mode_i   = 2'b11;
        bus.d_i      = 8'hFF;
        step();
        rst = 1'b0;
        check("rst_prio_q", bus.q_o, 8'h00);
        idle_inputs();
        model_q = '0;

        // ---- randomized run against the reference model ----
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_burst(bit'($urandom_range(0, 1)), CW'($urandom_range(0, 15)),
                         bit'($urandom_range(0, 1)), 1'b1, bit'($urandom_range(0, 1)));
            end else begin
                bit         en;
                logic [1:0] mode;
                logic [W-1:0] d;
                bit sr;
                bit sl;
                bit rot;
                en   = bit'($urandom_range(0, 3) != 0);
                mode = 2'($urandom_range(0, 3));
                d    = W'($urandom);
                sr   = bit'($urandom_range(0, 1));
                sl   = bit'($urandom_range(0, 1));
                rot  = bit'($urandom_range(0, 1));
                bus.enable_i   = en;
                bus.mode_i     = mode;
                bus.d_i        = d;
                bus.ser_in_r_i = sr;
                bus.ser_in_l_i = sl;
                bus.rotate_i   = rot;
                // Start with hold/load must be ignored.
                bus.start_i    = (mode == 2'b00 || mode == 2'b11) ? bit'($urandom_range(0, 1)) : 1'b0;
                bus.count_i    = CW'($urandom_range(0, 15));
                step();
                if (en) begin
                    case (mode)
                        2'b01:   model_q = ref_shift(model_q, 1'b0, sr, sl, rot);
                        2'b10:   model_q = ref_shift(model_q, 1'b1, sr, sl, rot);
                        2'b11:   model_q = d;
                        default: model_q = model_q;
                    endcase
                end
                check_q("rand", model_q);
                check("rand_busy", bus.busy_o, 1'b0);
                check("rand_done", bus.done_o, 1'b0);
                idle_inputs();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
